// File: rtl/synth_pkg.sv
// Shared types and constants for the register stream player.
// Register width, frame delimiter, default key set, FSM states.
package synth_pkg;

    localparam int          REG_W        = 8;
    localparam logic [7:0]  DEF_DELIM    = 8'hFF;
    localparam logic [35:0] DEF_KEY_MASK = 36'h0_4104_0201;

    typedef enum logic [1:0] {
        IDLE,
        GET_IDX,
        GET_VAL,
        APPLY
    } player_state_t;

endpackage

// File: rtl/tick_divider.sv
// Free-running strobe divider: one-cycle tick every TICK_DIV enabled cycles.
// Ports: clk_50mhz, reset (async high), enable (holds count when low), tick.
module tick_divider #(
    parameter int TICK_DIV = 5000000
) (
    input  logic clk_50mhz,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (enable) begin
                if (count == CW'(TICK_DIV - 1)) begin
                    count <= '0;
                    tick  <= 1'b1;
                end else begin
                    count <= count + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/reg_stream_player.sv
// Plays (index, value) byte pairs into a register bank, one frame per tick.
// Ports: clk_50mhz, reset, enable, s_valid/s_data/s_ready/s_eos stream,
// regs_flat bank, wr_* write echo, frame_tick, busy, done, status counters.
module reg_stream_player
    import synth_pkg::*;
#(
    parameter int                  NUM_REGS   = 36,
    parameter int                  TICK_DIV   = 5000000,
    parameter logic [NUM_REGS-1:0] KEY_MASK   = NUM_REGS'(DEF_KEY_MASK),
    parameter int                  TOGGLE_BIT = 6,
    parameter logic [7:0]          DELIM      = DEF_DELIM
) (
    input  logic                      clk_50mhz,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      s_valid,
    input  logic [7:0]                s_data,
    output logic                      s_ready,
    input  logic                      s_eos,
    output logic [REG_W*NUM_REGS-1:0] regs_flat,
    output logic                      wr_strobe,
    output logic [7:0]                wr_addr,
    output logic [7:0]                wr_data,
    output logic                      frame_tick,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               frame_count,
    output logic                      overrun,
    output logic [7:0]                bad_index_count
);

    localparam logic [7:0] TMASK = 8'(1 << TOGGLE_BIT);

    player_state_t state;
    logic [7:0]    idx;
    logic [7:0]    val;
    logic [7:0]    cur;
    logic [7:0]    new_val;
    logic          is_key;
    logic          in_range;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk_50mhz (clk_50mhz),
        .reset     (reset),
        .enable    (enable),
        .tick      (frame_tick)
    );

    assign s_ready = (state == GET_IDX) || (state == GET_VAL);
    assign busy    = (state != IDLE);
    assign done    = s_eos && (state == IDLE);

    // Key registers keep the written value except the toggle bit,
    // which flips so synth_core sees a retrigger on every write.
    always_comb begin
        cur    = '0;
        is_key = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == 8'(i)) begin
                cur    = regs_flat[REG_W*i +: REG_W];
                is_key = KEY_MASK[i];
            end
        end
        in_range = (idx < 8'(NUM_REGS));
        new_val  = is_key ? ((val & ~TMASK) | (~cur & TMASK)) : val;
    end

    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            idx             <= '0;
            val             <= '0;
            regs_flat       <= '0;
            wr_strobe       <= 1'b0;
            wr_addr         <= '0;
            wr_data         <= '0;
            frame_count     <= '0;
            overrun         <= 1'b0;
            bad_index_count <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (frame_tick && state != IDLE) begin
                overrun <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (frame_tick && !s_eos) begin
                        state <= GET_IDX;
                    end
                end
                GET_IDX: begin
                    if (s_valid) begin
                        if (s_data == DELIM) begin
                            state       <= IDLE;
                            frame_count <= frame_count + 16'd1;
                        end else begin
                            idx   <= s_data;
                            state <= GET_VAL;
                        end
                    end else if (s_eos) begin
                        state <= IDLE;
                    end
                end
                GET_VAL: begin
                    if (s_valid) begin
                        val   <= s_data;
                        state <= APPLY;
                    end else if (s_eos) begin
                        state <= IDLE;
                    end
                end
                APPLY: begin
                    if (in_range) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (idx == 8'(i)) begin
                                regs_flat[REG_W*i +: REG_W] <= new_val;
                            end
                        end
                        wr_strobe <= 1'b1;
                        wr_addr   <= idx;
                        wr_data   <= new_val;
                    end else if (bad_index_count != 8'hFF) begin
                        bad_index_count <= bad_index_count + 8'd1;
                    end
                    state <= GET_IDX;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/reg_stream_player.md
Name: reg_stream_player

Overview:
- Hardware replacement for file-driven register playback into synth_core.
- Consumes a byte stream of (index, value) pairs grouped into frames; each frame ends with delimiter 0xFF.
- Applies one frame per frame tick into a NUM_REGS x 8-bit register bank that drives synth_core's regs input.
- Key-on registers get toggle-bit retrigger semantics.
- Generalised over register count, key-register set, toggle bit and tick rate. Adds overrun, bad-index and end-of-stream status.

Parameters:
- NUM_REGS, 36, number of 8-bit registers in the bank (2..254).
- TICK_DIV, 5000000, clk_50mhz cycles per frame tick (10 Hz default).
- KEY_MASK, 36'h0_4104_0201, bit i set means register i is a key register. Default set is {0, 9, 18, 24, 30}.
- TOGGLE_BIT, 6, bit of a key register that toggles on every write instead of taking the written value.
- DELIM, 8'hFF, end-of-frame marker.

Ports:
- clk_50mhz  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  tick counter runs and frames start only while high.
- s_valid  in  1  stream byte valid.
- s_data  in  8  stream byte.
- s_ready  out  1  player accepts byte; transfer occurs when s_valid && s_ready.
- s_eos  in  1  source exhausted, level.
- regs_flat  out  8*NUM_REGS  register bank; register i is at [8i+7:8i].
- wr_strobe  out  1  one-cycle pulse per applied write.
- wr_addr  out  8  address of the applied write.
- wr_data  out  8  final stored value of the applied write.
- frame_tick  out  1  one-cycle pulse at each tick.
- busy  out  1  frame in progress.
- done  out  1  s_eos high and player idle, level.
- frame_count  out  16  frames completed, wraps at 0xFFFF -> 0.
- overrun  out  1  sticky; a tick arrived while busy.
- bad_index_count  out  8  count of out-of-range indices, saturates at 255.

Behaviour:
- Reset: all outputs 0, regs_flat 0, tick counter 0, state IDLE.
- Tick counter:
  - counts 0..TICK_DIV-1 while enable is high; frame_tick pulses on the cycle the count wraps to 0.
  - enable low holds the count and suppresses ticks.
- States:
  - IDLE:
    - s_ready=0.
    - frame_tick && !s_eos -> GET_IDX, busy=1.
    - frame_tick && s_eos -> stay IDLE.
  - GET_IDX:
    - s_ready=1.
    - On transfer, byte==DELIM -> IDLE, busy=0, frame_count+1 on the same edge.
    - On transfer, any other byte -> latch index, go to GET_VAL.
    - Stall while !s_valid.
    - s_eos && !s_valid -> IDLE without incrementing frame_count (partial frame ends).
  - GET_VAL:
    - s_ready=1.
    - On transfer -> APPLY.
    - s_eos && !s_valid -> IDLE, pending index dropped.
  - APPLY, 1 cycle, s_ready=0:
    - index < NUM_REGS and KEY_MASK[index]: new = {val[7:TOGGLE_BIT+1], ~cur[TOGGLE_BIT], val[TOGGLE_BIT-1:0]}.
    - index < NUM_REGS, non-key: new = val.
    - Register updates on the APPLY edge. wr_strobe/wr_addr/wr_data are registered and valid the next cycle.
    - index >= NUM_REGS: no write, no strobe, bad_index_count+1 (saturating).
    - Then -> GET_IDX.
- Throughput: at most one write per 3 cycles.
- Ticks while busy:
  - overrun set (sticky until reset); the tick is otherwise ignored.
  - The frame continues and no catch-up frame is played.
- A tick and frame completion on the same cycle counts as busy, so overrun is set.
- Repeated writes to one key register in a frame toggle TOGGLE_BIT each time.
- Simultaneous s_valid with s_eos: the byte is still consumed.
- done = s_eos && state==IDLE.
- Reset mid-frame aborts immediately; the bank clears to 0.

Decomposition:
- Package synth_pkg:
  - REG_W=8, DELIM default.
  - typedef player_state_t {IDLE, GET_IDX, GET_VAL, APPLY}.
  - default KEY_MASK constant.
- Sub-module tick_divider (TICK_DIV parameter; enable in, tick out) is natural and reused for the other sample-rate strobes.
- Register bank and toggle logic stay inline.

Test Plan:
- TICK_DIV=10, stream 03 2A FF: first tick -> regs[3]=0x2A, single wr_strobe with addr 3 / data 0x2A, frame_count=1, busy low after the FF byte.
- Key toggle, stream 00 80 FF 00 80 FF:
  - frame 1 -> regs[0]=0xC0.
  - frame 2 -> regs[0]=0x80.
  - Two writes in one frame (00 81 00 81 FF) from 0x00 -> 0xC1 then 0x81.
- Index 40 (NUM_REGS=36) with value 55: no write, no strobe, bad_index_count=1. Repeat 300 times -> saturates at 255.
- Frame of 8 pairs with TICK_DIV=10 and s_valid throttled to 1 of 4 cycles: overrun=1, all 8 writes applied in order, frame_count=1.
- s_eos asserted after 05 11 with no delimiter: 05 applied, returns to IDLE, frame_count unchanged, done=1, later ticks produce no s_ready.
- Reset asserted mid-GET_VAL: all regs 0, counters 0, s_ready 0 asynchronously. After release, the next tick restarts cleanly.
